// File: rtl/param_ring_counter_if.sv
// Control and status bundle for param_ring_counter.
// The master drives count controls; the slave (the counter) returns its registered state and pulses.
interface param_ring_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             err;
  logic             err_sticky;

  modport master (
    output en, mode, dir, load, load_val,
    input  q, wrap, err, err_sticky
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output q, wrap, err, err_sticky
  );
endinterface

// File: rtl/param_ring_counter.sv
// Parametrised one-hot / Johnson shift-register counter with up/down stepping,
// parallel load, self-correction of illegal states and registered wrap/err pulses.
module param_ring_counter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  param_ring_counter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;

  logic [CW-1:0]    pop_cnt;
  logic [CW-1:0]    trans_cnt;
  logic             legal;
  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] step_val;

  // Ones count for ring legality and adjacent-bit transition count (non-circular) for Johnson.
  always_comb begin
    pop_cnt   = '0;
    trans_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + CW'(q_q[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      trans_cnt = trans_cnt + CW'(q_q[i] ^ q_q[i+1]);
    end
  end

  assign legal = bus.mode ? (trans_cnt <= CW'(1)) : (pop_cnt == CW'(1));
  assign home  = bus.mode ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    unique case ({bus.mode, bus.dir})
      2'b00:   step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      2'b01:   step_val = {q_q[0], q_q[WIDTH-1:1]};
      2'b10:   step_val = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      default: step_val = {~q_q[0], q_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (bus.load) begin
      q_d = bus.load_val;
    end else if (bus.en) begin
      if (legal) begin
        q_d    = step_val;
        wrap_d = (step_val == home);
      end else begin
        q_d   = home;
        err_d = 1'b1;
      end
    end
    err_sticky_d = err_sticky_q | err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values, matching hardware.
    if (rst) begin
      q_q          <= {{(WIDTH-1){1'b0}}, 1'b1};
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      wrap_q       <= wrap_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.q          = q_q;
  assign bus.wrap       = wrap_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = err_sticky_q;

endmodule

// File: doc/param_ring_counter.md
Name: param_ring_counter

Overview:
- Parametrised shift-register counter. Successor to the fixed 8-bit self-starting one-hot ring counter.
- Width is generic. Two runtime-selectable modes:
  - one-hot ring: WIDTH states
  - Johnson (twisted ring): 2*WIDTH states
- Adds up/down direction, parallel load, illegal-state correction with error reporting, and a wrap pulse.
- Used as a phase/sequence generator and timing-slot strobe source in flow-control blocks.

Parameters:
- WIDTH, 8, number of flip-flops in the counter; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; state advances one step per clk edge while high.
- mode  input  1  0 = one-hot ring, 1 = Johnson; sampled on every edge.
- dir  input  1  0 = up (shift toward MSB), 1 = down (shift toward LSB).
- load  input  1  synchronous parallel load, independent of en.
- load_val  input  WIDTH  value written to q when load=1.
- q  output  WIDTH  registered counter state.
- wrap  output  1  registered one-cycle pulse when a normal step lands on the home state.
- err  output  1  registered one-cycle pulse when an illegal state is corrected.
- err_sticky  output  1  set by any err pulse; cleared only by rst.

Behaviour:
- Reset (async, rst=1): q=0...01 (legal in both modes), wrap=0, err=0, err_sticky=0. Takes effect immediately and holds while rst=1, including mid-sequence.
- Priority per edge: rst > load > en > hold.
- Load: q<=load_val, stored as-is with no legality check. wrap=0, err=0 that cycle.
- Hold (en=0, load=0): q unchanged, wrap=0, err=0.
- Legality, evaluated on current q against current mode:
  - Ring: exactly one bit set (popcount==1).
  - Johnson: at most one transition between adjacent bits q[i]/q[i+1], non-circular.
  - Johnson legal forms are 0..01..1 and 1..10..0, including all-0 and all-1.
- Enabled step, q legal:
  - Ring up: q <= {q[W-2:0], q[W-1]}.
  - Ring down: q <= {q[0], q[W-1:1]}.
  - Johnson up: q <= {q[W-2:0], ~q[W-1]}.
  - Johnson down: q <= {~q[0], q[W-1:1]}.
- Enabled step, q illegal:
  - q <= home of current mode; err=1 for one cycle; err_sticky<=1.
  - Ring home = 0...01. Ring all-zero counts as illegal and self-starts to home with err=1.
  - Johnson home = all-zero.
- wrap: 1 for exactly one cycle after an enabled legal step whose next q equals the current mode's home. Never asserted on load, correction or hold.
- Mode switch mid-count: the next enabled edge checks q against the new mode and corrects if illegal. Example: Johnson 0011 is illegal in ring and corrects to 0...01.
- Direction change takes effect on the same edge; no extra latency.
- Latency: q, wrap and err are valid one clk after the qualifying edge. All outputs are flops; no combinational path from inputs to outputs.
- Periods: ring is WIDTH enabled steps per wrap; Johnson is 2*WIDTH.
- Internal next-state logic is combinational from q/mode/dir. Popcount and transition-count logic scale with WIDTH.

Test Plan:
- Reset/ring up, WIDTH=8:
  - Stimulus: rst pulse, mode=0, dir=0, en=1 for 9 edges.
  - Response: q = 01,02,04,...,80,01. wrap=1 only in the cycle q=01 after 80. err stays 0.
- Johnson up, WIDTH=8:
  - Stimulus: load 00, mode=1, dir=0, en=1 for 16 edges.
  - Response: q = 01,03,07,...,FF,FE,FC,...,80,00. wrap=1 once, at 00. err=0.
- Down and direction change:
  - Stimulus: ring, q=01, dir=1, en=1.
  - Response: q=80, then 40. Set dir=0 on the next edge → 80.
  - Johnson down from 00 gives 80,C0,E0.
- Illegal-state correction:
  - Ring, load 00, en=1 → q=01, err=1, err_sticky=1.
  - Ring, load 5A → q=01, err=1.
  - Johnson, load 5A → q=00, err=1.
  - err_sticky stays 1 until rst.
- Enable/load priority:
  - en=0 for 5 edges → q constant, no pulses.
  - load=1 together with en=1 and load_val=0x10 → q=10, no step, wrap=0, err=0.
- Mode switch and async reset:
  - Johnson q=07, switch to mode=0 with en=1 → q=01, err=1.
  - Assert rst between clock edges → q=01 immediately and all pulses 0.
